// File: rtl/gsim_param.sv
// Gauss-Seidel solver for a 7-point banded system: collects N offsets b_i, sweeps
// x in place for a configurable number of iterations, then streams x_0..x_{N-1}.
module gsim_param #(
    parameter int N      = 16,
    parameter int B_W    = 16,
    parameter int X_W    = 32,
    parameter int FRAC   = 16,
    parameter int ITER_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_en,
    input  logic [B_W-1:0]         b_in,
    input  logic [ITER_W-1:0]      iter_cfg,
    output logic                   busy,
    output logic                   out_valid,
    output logic [X_W-1:0]         x_out,
    output logic [$clog2(N)-1:0]   out_idx
);

    localparam int IDX_W = $clog2(N);
    localparam int S_W   = X_W + 8;
    localparam int P_W   = S_W + 13;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        CALC,
        SEND
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;

    logic [IDX_W-1:0]         r_rcvCnt;
    logic [IDX_W-1:0]         r_sweepIdx;
    logic [ITER_W-1:0]        r_iterCnt;
    logic [ITER_W-1:0]        r_iterMax;

    logic                     r_outValid;
    logic [X_W-1:0]           r_xOut;
    logic [IDX_W-1:0]         r_outIdx;

    logic signed [B_W-1:0]    r_b [N];
    logic signed [X_W-1:0]    r_x [N];

    logic                     w_rcvLast;
    logic                     w_sweepLast;
    logic                     w_iterLast;

    logic signed [X_W-1:0]    w_nb [6];
    logic signed [S_W-1:0]    w_bTerm;
    logic signed [S_W-1:0]    w_s1;
    logic signed [S_W-1:0]    w_s2;
    logic signed [S_W-1:0]    w_s3;
    logic signed [S_W-1:0]    w_sum;
    logic signed [P_W-1:0]    w_prod;
    logic signed [P_W-1:0]    w_shift;
    logic signed [X_W-1:0]    w_xNew;

    assign busy      = (r_state != IDLE);
    assign out_valid = r_outValid;
    assign x_out     = r_xOut;
    assign out_idx   = r_outIdx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_rcvLast   = (r_rcvCnt == LAST_IDX);
        w_sweepLast = (r_sweepIdx == LAST_IDX);
        w_iterLast  = (r_iterCnt == (r_iterMax - ITER_W'(1)));
        case (r_state)
            IDLE: begin
                if (in_en) begin
                    w_nextState = RECEIVE;
                end
            end
            RECEIVE: begin
                if (in_en && w_rcvLast) begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                if (w_sweepLast && w_iterLast) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (w_sweepLast) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs are registered, so the first result appears one cycle after CALC ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rcvCnt   <= '0;
            r_sweepIdx <= '0;
            r_iterCnt  <= '0;
            r_iterMax  <= '0;
            r_outValid <= 1'b0;
            r_xOut     <= '0;
            r_outIdx   <= '0;
        end else begin
            r_outValid <= 1'b0;
            r_xOut     <= '0;
            r_outIdx   <= '0;
            case (r_state)
                IDLE: begin
                    if (in_en) begin
                        r_rcvCnt   <= IDX_W'(1);
                        r_iterMax  <= (iter_cfg == '0) ? ITER_W'(1) : iter_cfg;
                        r_sweepIdx <= '0;
                        r_iterCnt  <= '0;
                    end
                end
                RECEIVE: begin
                    if (in_en) begin
                        r_rcvCnt <= w_rcvLast ? '0 : r_rcvCnt + IDX_W'(1);
                    end
                end
                CALC: begin
                    r_sweepIdx <= w_sweepLast ? '0 : r_sweepIdx + IDX_W'(1);
                    if (w_sweepLast) begin
                        r_iterCnt <= r_iterCnt + ITER_W'(1);
                    end
                end
                SEND: begin
                    r_outValid <= 1'b1;
                    r_xOut     <= r_x[r_sweepIdx];
                    r_outIdx   <= r_sweepIdx;
                    r_sweepIdx <= w_sweepLast ? '0 : r_sweepIdx + IDX_W'(1);
                end
                default: begin
                    r_rcvCnt <= '0;
                end
            endcase
        end
    end

    // Operand storage carries no reset; a new solve always rewrites b and clears x first.
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (in_en) begin
                    r_b[0] <= b_in;
                    for (int k = 0; k < N; k++) begin
                        r_x[k] <= '0;
                    end
                end
            end
            RECEIVE: begin
                if (in_en) begin
                    r_b[r_rcvCnt] <= b_in;
                end
            end
            CALC: begin
                r_x[r_sweepIdx] <= w_xNew;
            end
            default: begin
            end
        endcase
    end

    // Neighbours at distance 1..3; out-of-range taps read as zero.
    always_comb begin
        for (int d = 1; d <= 3; d++) begin
            w_nb[2*d-2] = '0;
            w_nb[2*d-1] = '0;
            if (int'(r_sweepIdx) >= d) begin
                w_nb[2*d-2] = r_x[IDX_W'(int'(r_sweepIdx) - d)];
            end
            if (int'(r_sweepIdx) + d < N) begin
                w_nb[2*d-1] = r_x[IDX_W'(int'(r_sweepIdx) + d)];
            end
        end

        w_bTerm = S_W'(r_b[r_sweepIdx]) <<< FRAC;
        w_s1    = S_W'(w_nb[0]) + S_W'(w_nb[1]);
        w_s2    = S_W'(w_nb[2]) + S_W'(w_nb[3]);
        w_s3    = S_W'(w_nb[4]) + S_W'(w_nb[5]);
        w_sum   = w_bTerm + S_W'(13) * w_s1 - S_W'(6) * w_s2 + w_s3;

        // 3277/65536 approximates 1/20, the diagonal of the system.
        w_prod  = P_W'(w_sum) * P_W'(3277);
        w_shift = w_prod >>> 16;

        w_xNew = w_shift[X_W-1:0];
        if (!((&w_shift[P_W-1:X_W-1]) || !(|w_shift[P_W-1:X_W-1]))) begin
            w_xNew = w_shift[P_W-1] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
        end
    end

endmodule

// File: tb/tb_gsim_param.sv
// Self-checking bench for gsim_param: four instances (N=16, N=4, N=64, and a wide-b
// N=16 for saturation) share stimulus; a behavioural model fills a scoreboard queue.
module tb_gsim_param;

   typedef struct {
      int     idx;
      longint x;
   } exp_t;

   localparam longint XMAX = 64'sd2147483647;
   localparam longint XMIN = -64'sd2147483648;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic                inEn;
   logic signed [19:0]  bIn;
   logic [7:0]          iterCfg;
   int                  sel;

   logic [3:0]  en;
   logic [3:0]  busyD;
   logic [3:0]  vldD;
   logic [31:0] x0, x1, x2, x3;
   logic [3:0]  idx0;
   logic [1:0]  idx1;
   logic [5:0]  idx2;
   logic [3:0]  idx3;

   logic               vld;
   logic               bsy;
   logic signed [31:0] xo;
   int                 idx;

   exp_t   q[$];
   int     mb[64];
   longint mx[64];
   int     nChecks = 0;
   int     nErr = 0;
   longint storeT = 0;
   int     expLat = 0;
   bit     latArm = 1'b0;

   assign en[0] = inEn && (sel == 0);
   assign en[1] = inEn && (sel == 1);
   assign en[2] = inEn && (sel == 2);
   assign en[3] = inEn && (sel == 3);

   gsim_param #(.N(16)) u16 (
      .clk(clk), .reset(reset), .in_en(en[0]), .b_in(bIn[15:0]), .iter_cfg(iterCfg),
      .busy(busyD[0]), .out_valid(vldD[0]), .x_out(x0), .out_idx(idx0));

   gsim_param #(.N(4)) u4 (
      .clk(clk), .reset(reset), .in_en(en[1]), .b_in(bIn[15:0]), .iter_cfg(iterCfg),
      .busy(busyD[1]), .out_valid(vldD[1]), .x_out(x1), .out_idx(idx1));

   gsim_param #(.N(64)) u64 (
      .clk(clk), .reset(reset), .in_en(en[2]), .b_in(bIn[15:0]), .iter_cfg(iterCfg),
      .busy(busyD[2]), .out_valid(vldD[2]), .x_out(x2), .out_idx(idx2));

   gsim_param #(.N(16), .B_W(20)) u16w (
      .clk(clk), .reset(reset), .in_en(en[3]), .b_in(bIn), .iter_cfg(iterCfg),
      .busy(busyD[3]), .out_valid(vldD[3]), .x_out(x3), .out_idx(idx3));

   // Route the instance under test onto one set of observation signals.
   always_comb begin
      vld = 1'b0;
      bsy = 1'b0;
      xo  = '0;
      idx = 0;
      case (sel)
         0: begin vld = vldD[0]; bsy = busyD[0]; xo = x0; idx = int'(idx0); end
         1: begin vld = vldD[1]; bsy = busyD[1]; xo = x1; idx = int'(idx1); end
         2: begin vld = vldD[2]; bsy = busyD[2]; xo = x2; idx = int'(idx2); end
         default: begin vld = vldD[3]; bsy = busyD[3]; xo = x3; idx = int'(idx3); end
      endcase
   end

   task automatic checkOutput(input string tag, input longint got, input longint expv);
      nChecks++;
      if (got != expv) begin
         nErr++;
         $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, got, expv, $time);
      end
   endtask

   function automatic longint gx(input int k, input int n);
      if (k < 0 || k >= n) return 0;
      return mx[k];
   endfunction

   // Reference Gauss-Seidel sweeps on 64-bit integers.
   task automatic runModel(input int n, input int it);
      longint s;
      longint t;
      for (int k = 0; k < n; k++) mx[k] = 0;
      for (int r = 0; r < it; r++) begin
         for (int i = 0; i < n; i++) begin
            s = longint'(mb[i]) * 65536
                + 13 * (gx(i - 1, n) + gx(i + 1, n))
                - 6 * (gx(i - 2, n) + gx(i + 2, n))
                + (gx(i - 3, n) + gx(i + 3, n));
            t = (s * 3277) >>> 16;
            if (t > XMAX) t = XMAX;
            else if (t < XMIN) t = XMIN;
            mx[i] = t;
         end
      end
   endtask

   // Every cycle with out_valid pops one expectation; an empty queue means a stray output.
   always @(negedge clk) begin
      exp_t e;
      if (vld) begin
         if (latArm) begin
            checkOutput("latency", (longint'($time) - storeT - 5) / 10, longint'(expLat));
            latArm = 1'b0;
         end
         if (q.size() == 0) begin
            checkOutput("extraValid", 1, 0);
         end else begin
            e = q.pop_front();
            checkOutput("outIdx", longint'(idx), longint'(e.idx));
            checkOutput("xOut", longint'(xo), e.x);
         end
      end
   end

   task automatic applyStimulus(input int dsel, input int n, input int iter,
                                input int gapPct, input bit noisy);
      int it;
      it = (iter == 0) ? 1 : iter;
      @(posedge clk);
      #1;
      sel = dsel;
      runModel(n, it);
      for (int k = 0; k < n; k++) q.push_back('{k, mx[k]});
      for (int i = 0; i < n; i++) begin
         while (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
            inEn    = 1'b0;
            bIn     = 20'($urandom);
            iterCfg = 8'($urandom);
            @(posedge clk);
            #1;
         end
         inEn    = 1'b1;
         bIn     = 20'(mb[i]);
         iterCfg = (i == 0) ? 8'(iter) : 8'($urandom);
         @(posedge clk);
         storeT = longint'($time);
         #1;
      end
      inEn   = 1'b0;
      expLat = n * it + 1;
      latArm = 1'b1;
      if (noisy) begin
         for (int k = 1; k <= n * it + n; k++) begin
            inEn = 1'b1;
            bIn  = 20'($urandom);
            @(posedge clk);
            #1;
         end
         inEn = 1'b0;
      end
   endtask

   task automatic waitDone(input int bound);
      for (int c = 0; c < bound && q.size() > 0; c++) @(negedge clk);
      checkOutput("drain", longint'(q.size()), 0);
      q.delete();
      latArm = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("idleValid", longint'(vld), 0);
      checkOutput("idleX", longint'(xo), 0);
      checkOutput("idleIdx", longint'(idx), 0);
      checkOutput("idleBusy", longint'(bsy), 0);
   endtask

   task automatic fillRandom(input int n, input int lo, input int hi);
      for (int i = 0; i < n; i++) mb[i] = lo + int'($urandom_range(hi - lo));
   endtask

   task automatic abortRun(input int cyclesIn);
      fillRandom(16, -32768, 32767);
      applyStimulus(0, 16, 2, 0, 1'b0);
      repeat (cyclesIn) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rstBusy", longint'(bsy), 0);
      checkOutput("rstValid", longint'(vld), 0);
      checkOutput("rstX", longint'(xo), 0);
      checkOutput("rstIdx", longint'(idx), 0);
      q.delete();
      latArm = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (60) @(negedge clk);
      checkOutput("abortBusy", longint'(bsy), 0);
   endtask

   initial begin
      reset   = 1'b1;
      inEn    = 1'b0;
      bIn     = '0;
      iterCfg = '0;
      sel     = 0;
      #1;
      reset = 1'b0;
      #1;
      checkOutput("resetBusy", longint'(bsy), 0);
      checkOutput("resetValid", longint'(vld), 0);
      checkOutput("resetX", longint'(xo), 0);
      checkOutput("resetIdx", longint'(idx), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      $display("[TB] zero solve");
      for (int i = 0; i < 64; i++) mb[i] = 0;
      applyStimulus(0, 16, 1, 0, 1'b0);
      waitDone(100);

      $display("[TB] impulse");
      mb[0] = 20;
      applyStimulus(0, 16, 1, 0, 1'b0);
      waitDone(100);

      $display("[TB] random b, gap-free, gapped with noise, iter_cfg=0");
      fillRandom(16, -32768, 32767);
      applyStimulus(0, 16, 1, 0, 1'b0);
      waitDone(100);
      applyStimulus(0, 16, 1, 30, 1'b1);
      waitDone(100);
      applyStimulus(0, 16, 0, 20, 1'b0);
      waitDone(100);

      $display("[TB] 50 sweeps");
      fillRandom(16, -32768, 32767);
      applyStimulus(0, 16, 50, 0, 1'b0);
      waitDone(1000);

      $display("[TB] N=4 and N=64");
      fillRandom(4, -32768, 32767);
      applyStimulus(1, 4, 3, 10, 1'b1);
      waitDone(100);
      fillRandom(64, -32768, 32767);
      applyStimulus(2, 64, 2, 10, 1'b0);
      waitDone(300);

      $display("[TB] saturation");
      for (int i = 0; i < 16; i++) mb[i] = ($urandom_range(3) == 0) ? -524288 : 524287;
      applyStimulus(3, 16, 3, 0, 1'b0);
      waitDone(150);

      $display("[TB] reset aborts");
      abortRun(10);
      abortRun(38);
      fillRandom(16, -32768, 32767);
      applyStimulus(0, 16, 1, 0, 1'b0);
      waitDone(100);

      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/gsim_param.md
GSIM_PARAM -- requirements
Module: gsim_param

Interface
REQ-001 Parameter N, default 16: number of unknowns; legal range 4..64.
REQ-002 Parameter B_W, default 16: width of the signed integer b_in.
REQ-003 Parameter X_W, default 32: width of the signed fixed-point x_out.
REQ-004 Parameter FRAC, default 16: fractional bits of x_out.
REQ-005 Parameter ITER_W, default 8: width of iter_cfg.
REQ-006 Port clk, input, 1: single clock; all state updates occur on the rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port in_en, input, 1: b_in is valid this cycle.
REQ-009 Port b_in, input, B_W: signed offset b_i, presented in order i = 0..N-1.
REQ-010 Port iter_cfg, input, ITER_W: sweep count, sampled with the first b word.
REQ-011 Port busy, output, 1: high in all states other than IDLE.
REQ-012 Port out_valid, output, 1: x_out and out_idx are valid this cycle.
REQ-013 Port x_out, output, X_W: solution x_k, signed, with FRAC fractional bits.
REQ-014 Port out_idx, output, clog2(N): index k of the current x_out.

Function
REQ-015 The FSM SHALL have four states: IDLE, RECEIVE, CALC and SEND.
REQ-016 In IDLE, in_en=1 SHALL store b_in as b_0, capture iter_cfg, clear every x_i to 0, and move to RECEIVE; if N words are already complete, the FSM SHALL go to CALC instead.
REQ-017 A captured iter_cfg of 0 SHALL be treated as 1.
REQ-018 In RECEIVE, each in_en=1 cycle SHALL store the next b_i; in_en=0 cycles SHALL be gaps that hold the count and do not abort.
REQ-019 The cycle that stores b_{N-1} SHALL move the FSM to CALC on the next edge.
REQ-020 CALC SHALL update one unknown per cycle, sweeping i = 0..N-1 in place, so each update uses the newest x values (Gauss-Seidel).
REQ-021 The update sum SHALL be S = (b_i << FRAC) + 13(x_{i-1}+x_{i+1}) - 6(x_{i-2}+x_{i+2}) + (x_{i-3}+x_{i+3}).
REQ-022 Any x index outside 0..N-1 in S SHALL contribute 0.
REQ-023 S SHALL be computed signed in X_W+8 bits with no intermediate overflow.
REQ-024 The new x_i SHALL be (S * 3277) >>> 16, an arithmetic shift truncating toward minus infinity, saturated to the signed X_W range.
REQ-025 CALC SHALL last exactly N * iter cycles, after which the FSM SHALL move to SEND.
REQ-026 SEND SHALL assert out_valid for exactly N consecutive cycles with out_idx = k and x_out = x_k for k = 0..N-1, then return to IDLE.
REQ-027 When out_valid=0, x_out and out_idx SHALL be 0.
REQ-028 in_en SHALL be ignored in CALC and SEND; those b words are discarded.
REQ-029 in_en=1 in the IDLE cycle that follows the last SEND cycle SHALL start a new solve, and b SHALL be fully overwritten.
REQ-030 Latency from the edge that stores b_{N-1} to the first out_valid SHALL be N*iter + 1 cycles.

Reset
REQ-031 reset=0 SHALL immediately force state to IDLE and busy, out_valid, x_out and out_idx to 0, and clear the receive, sweep and iteration counters.
REQ-032 Reset asserted in any state, including mid-CALC or mid-SEND, SHALL abort the solve with no further out_valid.
REQ-033 After reset deasserts, the first in_en=1 SHALL be taken as b_0.
REQ-034 The b and x storage need not be reset.

Verification
REQ-035 Reset: drive reset=0 mid-stream -> busy, out_valid, x_out and out_idx read 0 in the same cycle; the next solve behaves normally.
REQ-036 Zero solve: N=16, all b=0, iter_cfg=1 -> out_valid high for exactly 16 cycles with x_out=0 and out_idx 0..15; first out_valid 17 cycles after the edge that stores b_15.
REQ-037 Impulse: N=16, b_0=20 and all other b=0, iter_cfg=1 -> x_0=0x00010004 and x_1=0x0000A66B; all outputs match a bit-exact golden model of REQ-021..024.
REQ-038 Gapped input: random in_en gaps during RECEIVE, plus in_en=1 during CALC and SEND -> results identical to the gap-free run.
REQ-039 iter_cfg=0 -> output identical to the iter_cfg=1 run; iter_cfg=50 on random b -> matches the golden model after 50 sweeps, with CALC lasting 800 cycles.
REQ-040 Parameter sweep: N=4 and N=64 with X_W=32, plus a large-b case that drives x to the saturation limit -> results match the golden model, with no wrap-around.
